pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives stall/flush for the IF, ID and ID/EX segment registers and operand-forwarding selects for EX.
- Keeps its own shadow of the E/M/W destination-register fields. The datapath only feeds it decode-stage information plus the EX branch resolution.
- Sits beside segment_id_ex; its FlushE output clears that segment.

Parameters:
- LD_STALL_CYC, 1, cycles IF/ID are held after a load-use hazard is detected (1..3).
- BR_FLUSH_CYC, 2, cycles FlushD/FlushE stay asserted after a taken branch (1..3).
- PC_REG, 15, register index never forwarded or hazard-checked (PC).

Ports:
- clk  in  1  pipeline clock; all state updates on negedge, same edge as the segment registers.
- rst  in  1  asynchronous reset, active-low.
- RA1D  in  4  decode-stage source register 1.
- RA2D  in  4  decode-stage source register 2.
- Use1D  in  1  RA1D is actually read by the instruction in D.
- Use2D  in  1  RA2D is actually read by the instruction in D.
- WA3D  in  4  decode-stage destination register.
- RegWriteD  in  1  instruction in D writes the register file.
- MemtoRegD  in  1  instruction in D is a load.
- BranchTakenE  in  1  branch in EX resolved taken (PCSrcE & condition true).
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  clear ID/EX (bubble).
- ForwardAE  out  2  EX operand A select: 00 reg file, 01 W result, 10 M ALU result.
- ForwardBE  out  2  EX operand B select, same encoding.
- StallCnt  out  16  perf counter (see Optional Feature).
- FlushCnt  out  16  perf counter (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to RUN, counters cleared.
  - All shadow valid/RegWrite/MemtoReg bits to 0, shadow register fields to 0.
  - While rst=0, every output is forced 0.
- Shadow pipeline, updated each negedge:
  - E takes {RA1D&Use1D, RA2D&Use2D, WA3D, RegWriteD, MemtoRegD}. When FlushE=1 at that edge, E takes a bubble (all enables 0) instead.
  - M takes E; W takes M.
- Forwarding (combinational from shadow):
  - ForwardAE=10 if RegWriteM & WA3M==RA1E & RA1E used & RA1E!=PC_REG.
  - Otherwise 01 on the same test against W.
  - Otherwise 00. M takes priority over W. B operand is identical with RA2E.
- Load-use detect (combinational):
  - LU = MemtoRegE & RegWriteE & WA3E!=PC_REG & ((Use1D & RA1D==WA3E) | (Use2D & RA2D==WA3E)).
- FSM states:
  - RUN: no outputs asserted apart from forwarding.
    - BranchTakenE goes to BRF with cnt=BR_FLUSH_CYC-1.
    - Else LU goes to LUS with cnt=LD_STALL_CYC-1.
    - In the detecting cycle the outputs of the target state are already driven (Mealy).
  - LUS: StallF=StallD=1, FlushE=1.
    - cnt==0 returns to RUN; else cnt-1.
    - BranchTakenE during LUS aborts to BRF: the flush wins and stalls drop that cycle.
  - BRF: FlushD=FlushE=1, StallF=StallD=0.
    - cnt==0 returns to RUN; else cnt-1.
    - A new BranchTakenE in BRF is ignored, because the flushed EX cannot carry a valid branch.
- Simultaneous branch and load-use: the branch wins, and no stall is issued.
- StallD=1 and FlushD=1 are never asserted together.
- Reset mid-stall or mid-flush returns to RUN immediately with outputs 0.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined:
  - StallCnt increments on each negedge with StallD=1.
  - FlushCnt increments on each negedge with FlushE=1.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: the counter logic is omitted and StallCnt=FlushCnt=16'h0 constant.

Test Plan:
- Reset: hold rst=0 with BranchTakenE=1 and LU conditions present -> all outputs 0. Release -> first cycle shows RUN behaviour, ForwardAE/BE=00.
- Back-to-back ALU ops: ADD R1 then SUB R2,R1,R1 -> next EX cycle ForwardAE=ForwardBE=10. With one independent op inserted between -> 01. Same dest R1 in both M and W -> 10.
- Load-use: LDR R3 in E, D reads RA2D=3 with Use2D=1, LD_STALL_CYC=1 -> exactly 1 cycle StallF=StallD=FlushE=1, then ForwardBE=01. Repeat with RA2D=15 -> no stall.
- Taken branch, BR_FLUSH_CYC=2 -> FlushD=FlushE=1 for 2 cycles, stalls 0. A second BranchTakenE in cycle 2 does not extend the flush.
- Simultaneous LU and BranchTakenE=1 -> BRF entered, StallD=0, FlushD=FlushE=1. Separately, assert rst=0 mid-LUS -> outputs 0 asynchronously, RUN after release.
- With HAZ_PERF_CNT_EN: 3 load-use stalls plus 1 branch -> StallCnt=3, FlushCnt=5. Preload near max -> counters saturate at 16'hFFFF. Without the macro -> both read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the decode-stage information, the EX branch resolution and the
// hazard-control outputs exchanged between the pipeline datapath and
// pipeline_hazard_ctrl.
//   master : datapath side (drives decode info, consumes stall/flush/forward)
//   slave  : hazard controller side
// Signals:
//   RA1D, RA2D, WA3D [3:0]   decode-stage source/destination register indices
//   Use1D, Use2D             source register actually read by the D instruction
//   RegWriteD, MemtoRegD     D instruction writes the register file / is a load
//   BranchTakenE             branch in EX resolved taken
//   StallF, StallD           hold PC / hold IF-ID
//   FlushD, FlushE           clear IF-ID / clear ID-EX
//   ForwardAE, ForwardBE     EX operand selects (00 RF, 01 W result, 10 M ALU)
//   StallCnt, FlushCnt       performance counters
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic [3:0]  RA1D;
    logic [3:0]  RA2D;
    logic        Use1D;
    logic        Use2D;
    logic [3:0]  WA3D;
    logic        RegWriteD;
    logic        MemtoRegD;
    logic        BranchTakenE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [15:0] StallCnt;
    logic [15:0] FlushCnt;

    modport master (
        output RA1D, RA2D, Use1D, Use2D, WA3D, RegWriteD, MemtoRegD, BranchTakenE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt, FlushCnt
    );

    modport slave (
        input  RA1D, RA2D, Use1D, Use2D, WA3D, RegWriteD, MemtoRegD, BranchTakenE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt, FlushCnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage pipeline. Keeps a shadow of
// the E/M/W register fields, derives EX operand forwarding from it, detects
// load-use hazards against the decode stage and sequences stall/flush windows.
// All state updates on the falling clock edge, matching the segment registers.
// Ports:
//   clk  pipeline clock (negedge active)
//   rst  asynchronous reset, active-low; every output reads 0 while low
//   hz   pipeline_hazard_ctrl_if.slave (decode info in, hazard controls out)
// Parameters:
//   LD_STALL_CYC  cycles IF/ID are held after a load-use hazard (1..3)
//   BR_FLUSH_CYC  cycles FlushD/FlushE stay high after a taken branch (1..3)
//   PC_REG        register index never forwarded or hazard-checked
// Optional feature macro: HAZ_PERF_CNT_EN enables the saturating StallCnt and
// FlushCnt performance counters; otherwise both read constant 0.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int         LD_STALL_CYC = 1,
    parameter int         BR_FLUSH_CYC = 2,
    parameter logic [3:0] PC_REG       = 4'd15
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_LUS = 2'd1,
        ST_BRF = 2'd2
    } state_t;

    // cnt_q counts the asserted cycles still owed, including the current one.
    // The detecting cycle (in RUN) is the first asserted cycle, so a 1-cycle
    // window never leaves RUN at all.
    localparam logic [1:0] LD_EXTRA = 2'(LD_STALL_CYC - 1);
    localparam logic [1:0] BR_EXTRA = 2'(BR_FLUSH_CYC - 1);
    localparam state_t     LD_NEXT  = (LD_EXTRA != 2'd0) ? ST_LUS : ST_RUN;
    localparam state_t     BR_NEXT  = (BR_EXTRA != 2'd0) ? ST_BRF : ST_RUN;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;

    // Shadow of E, M and W: only the fields the hazard logic looks at.
    logic [3:0]  ra1_e_q, ra2_e_q, wa3_e_q, wa3_m_q, wa3_w_q;
    logic        use1_e_q, use2_e_q, regwr_e_q, memtoreg_e_q;
    logic        regwr_m_q, regwr_w_q;

    logic        lu_s;
    logic        stall_s, flush_d_s, flush_e_s;
    logic [1:0]  fwd_a_s, fwd_b_s;

    // M has priority over W because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra, input logic used,
        input logic       wr_m, input logic [3:0] wa_m,
        input logic       wr_w, input logic [3:0] wa_w
    );
        logic [1:0] sel;
        if (used && (ra != PC_REG) && wr_m && (wa_m == ra)) begin
            sel = 2'b10;
        end else if (used && (ra != PC_REG) && wr_w && (wa_w == ra)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects and load-use detection from the shadow pipeline.
    always_comb begin
        fwd_a_s = fwd_sel(ra1_e_q, use1_e_q, regwr_m_q, wa3_m_q, regwr_w_q, wa3_w_q);
        fwd_b_s = fwd_sel(ra2_e_q, use2_e_q, regwr_m_q, wa3_m_q, regwr_w_q, wa3_w_q);
        lu_s    = memtoreg_e_q && regwr_e_q && (wa3_e_q != PC_REG) &&
                  ((hz.Use1D && (hz.RA1D == wa3_e_q)) ||
                   (hz.Use2D && (hz.RA2D == wa3_e_q)));
    end

    // Sequencer next-state and Mealy stall/flush outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_s   = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.BranchTakenE) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    state_d   = BR_NEXT;
                    cnt_d     = BR_EXTRA;
                end else if (lu_s) begin
                    stall_s   = 1'b1;
                    flush_e_s = 1'b1;
                    state_d   = LD_NEXT;
                    cnt_d     = LD_EXTRA;
                end else begin
                    state_d   = ST_RUN;
                    cnt_d     = 2'd0;
                end
            end
            ST_LUS: begin
                // A taken branch aborts the stall; the flush wins this cycle.
                if (hz.BranchTakenE) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    state_d   = BR_NEXT;
                    cnt_d     = BR_EXTRA;
                end else if (cnt_q <= 2'd1) begin
                    stall_s   = 1'b1;
                    flush_e_s = 1'b1;
                    state_d   = ST_RUN;
                    cnt_d     = 2'd0;
                end else begin
                    stall_s   = 1'b1;
                    flush_e_s = 1'b1;
                    cnt_d     = cnt_q - 2'd1;
                end
            end
            ST_BRF: begin
                // EX holds a bubble here, so any BranchTakenE is ignored.
                flush_d_s = 1'b1;
                flush_e_s = 1'b1;
                if (cnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shadow pipeline advance; a flushed ID/EX enters E as a bubble.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ra1_e_q <= 4'd0; ra2_e_q <= 4'd0; wa3_e_q <= 4'd0;
            use1_e_q <= 1'b0; use2_e_q <= 1'b0;
            regwr_e_q <= 1'b0; memtoreg_e_q <= 1'b0;
            wa3_m_q <= 4'd0; regwr_m_q <= 1'b0;
            wa3_w_q <= 4'd0; regwr_w_q <= 1'b0;
        end else begin
            if (flush_e_s) begin
                ra1_e_q <= 4'd0; ra2_e_q <= 4'd0; wa3_e_q <= 4'd0;
                use1_e_q <= 1'b0; use2_e_q <= 1'b0;
                regwr_e_q <= 1'b0; memtoreg_e_q <= 1'b0;
            end else begin
                ra1_e_q <= hz.RA1D; ra2_e_q <= hz.RA2D; wa3_e_q <= hz.WA3D;
                use1_e_q <= hz.Use1D; use2_e_q <= hz.Use2D;
                regwr_e_q <= hz.RegWriteD; memtoreg_e_q <= hz.MemtoRegD;
            end
            wa3_m_q   <= wa3_e_q;
            regwr_m_q <= regwr_e_q;
            wa3_w_q   <= wa3_m_q;
            regwr_w_q <= regwr_m_q;
        end
    end

    assign hz.StallF    = rst ? stall_s   : 1'b0;
    assign hz.StallD    = rst ? stall_s   : 1'b0;
    assign hz.FlushD    = rst ? flush_d_s : 1'b0;
    assign hz.FlushE    = rst ? flush_e_s : 1'b0;
    assign hz.ForwardAE = rst ? fwd_a_s   : 2'b00;
    assign hz.ForwardBE = rst ? fwd_b_s   : 2'b00;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    // Saturating stall/flush cycle counters.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_e_s && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign hz.StallCnt = rst ? stall_cnt_q : 16'h0000;
    assign hz.FlushCnt = rst ? flush_cnt_q : 16'h0000;
`else
    assign hz.StallCnt = 16'h0000;
    assign hz.FlushCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    localparam int         LD = 1;
    localparam int         BR = 2;
    localparam logic [3:0] PC = 4'd15;

    logic clk = 1'b1;
    logic rst;

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(.LD_STALL_CYC(LD), .BR_FLUSH_CYC(BR), .PC_REG(PC)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s1, s2, d;
        logic       u1, u2, wr, ld;
    } instr_t;

    typedef struct {
        logic       sf, sd, fd, fe;
        logic [1:0] fa, fb;
        logic [15:0] sc, fc;
        int         cyc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    instr_t pipe[3];          // reference pipeline: 0=E, 1=M, 2=W
    int     flush_left, stall_left, scnt, fcnt, cyc_n;
    int     checks = 0;
    int     passes = 0;
    logic   last_stall, last_flushd;

    function automatic instr_t mk(input logic [3:0] s1, input logic u1,
                                  input logic [3:0] s2, input logic u2,
                                  input logic [3:0] d, input logic wr, input logic ld);
        instr_t n;
        n.s1 = s1; n.u1 = u1; n.s2 = s2; n.u2 = u2; n.d = d; n.wr = wr; n.ld = ld;
        return n;
    endfunction

    function automatic instr_t nop();
        return mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endfunction

    function automatic logic [3:0] pick_reg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 4'd15 : 4'(k);
    endfunction

    function automatic instr_t rnd();
        instr_t n;
        n.s1 = pick_reg(); n.s2 = pick_reg(); n.d = pick_reg();
        n.u1 = 1'($urandom_range(0, 1)); n.u2 = 1'($urandom_range(0, 1));
        n.wr = ($urandom_range(0, 3) != 0);
        n.ld = ($urandom_range(0, 2) == 0);
        return n;
    endfunction

    // Result source for an EX operand: youngest writer of that register wins.
    function automatic logic [1:0] fwd(input logic [3:0] r, input logic u);
        if (!u || r == PC)                    return 2'b00;
        if (pipe[1].wr && pipe[1].d == r)     return 2'b10;
        if (pipe[2].wr && pipe[2].d == r)     return 2'b01;
        return 2'b00;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req, input int cyc);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endfunction

    // One pipeline cycle: drive D-stage inputs, predict outputs, advance model.
    task automatic cyc(input logic rv, input instr_t i, input logic br);
        exp_t e;
        logic lu;
        @(negedge clk);
        #1;
        rst = rv;
        hz.RA1D = i.s1; hz.RA2D = i.s2; hz.Use1D = i.u1; hz.Use2D = i.u2;
        hz.WA3D = i.d; hz.RegWriteD = i.wr; hz.MemtoRegD = i.ld;
        hz.BranchTakenE = br;
        e.sf = 1'b0; e.sd = 1'b0; e.fd = 1'b0; e.fe = 1'b0;
        e.fa = 2'b00; e.fb = 2'b00; e.sc = 16'h0; e.fc = 16'h0;
        e.cyc = cyc_n;
        if (!rv) begin
            for (int k = 0; k < 3; k++) pipe[k] = nop();
            flush_left = 0; stall_left = 0; scnt = 0; fcnt = 0;
        end else begin
            lu = pipe[0].ld && pipe[0].wr && pipe[0].d != PC &&
                 ((i.u1 && i.s1 == pipe[0].d) || (i.u2 && i.s2 == pipe[0].d));
            e.fa = fwd(pipe[0].s1, pipe[0].u1);
            e.fb = fwd(pipe[0].s2, pipe[0].u2);
`ifdef HAZ_PERF_CNT_EN
            e.sc = 16'(scnt);
            e.fc = 16'(fcnt);
`endif
            if (flush_left > 0) begin
                e.fd = 1'b1; e.fe = 1'b1; flush_left--;
            end else if (br) begin
                e.fd = 1'b1; e.fe = 1'b1; flush_left = BR - 1; stall_left = 0;
            end else if (stall_left > 0) begin
                e.sf = 1'b1; e.sd = 1'b1; e.fe = 1'b1; stall_left--;
            end else if (lu) begin
                e.sf = 1'b1; e.sd = 1'b1; e.fe = 1'b1; stall_left = LD - 1;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e.fe ? nop() : i;
            if (e.sd && scnt < 65535) scnt++;
            if (e.fe && fcnt < 65535) fcnt++;
        end
        last_stall  = e.sd;
        last_flushd = e.fd;
        exp_q.push_back(e);
        cyc_n++;
    endtask

    // Monitor: compare the DUT outputs of each cycle against the queued prediction.
    always @(posedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("stall_flush", {28'd0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE},
                {28'd0, mon_e.sf, mon_e.sd, mon_e.fd, mon_e.fe}, mon_e.cyc);
            chk("ForwardAE", {30'd0, hz.ForwardAE}, {30'd0, mon_e.fa}, mon_e.cyc);
            chk("ForwardBE", {30'd0, hz.ForwardBE}, {30'd0, mon_e.fb}, mon_e.cyc);
            chk("perf_cnt", {hz.StallCnt, hz.FlushCnt}, {mon_e.sc, mon_e.fc}, mon_e.cyc);
        end
    end

    initial begin
        instr_t cur;
        logic   rv;
        logic   br;
        rst = 1'b0;
        hz.RA1D = 4'd0; hz.RA2D = 4'd0; hz.Use1D = 1'b0; hz.Use2D = 1'b0;
        hz.WA3D = 4'd0; hz.RegWriteD = 1'b0; hz.MemtoRegD = 1'b0; hz.BranchTakenE = 1'b0;
        for (int k = 0; k < 3; k++) pipe[k] = nop();
        flush_left = 0; stall_left = 0; scnt = 0; fcnt = 0; cyc_n = 0;
        last_stall = 1'b0; last_flushd = 1'b0;

        // Reset held with a branch and load-use-like decode present.
        repeat (3) cyc(1'b0, mk(4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1), 1'b1);
        cyc(1'b1, nop(), 1'b0);
        // ADD R1 ; SUB R2,R1,R1
        cyc(1'b1, mk(4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(4'd1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        // ADD R1 ; independent op ; SUB R2,R1,R1
        cyc(1'b1, mk(4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(4'd4, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(4'd1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        // R1 written in both M and W
        cyc(1'b1, mk(4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(4'd1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        // LDR R3 ; use R3 on operand B (held one cycle by the stall)
        cyc(1'b1, mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1), 1'b0);
        cyc(1'b1, mk(4'd4, 1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, mk(4'd4, 1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        // Load to PC register never stalls
        cyc(1'b1, mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b1), 1'b0);
        cyc(1'b1, mk(4'd4, 1'b1, 4'd15, 1'b1, 4'd5, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        // Taken branch, second branch inside the window is ignored
        cyc(1'b1, nop(), 1'b1);
        cyc(1'b1, nop(), 1'b1);
        cyc(1'b1, nop(), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        // Load-use and branch in the same cycle
        cyc(1'b1, mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1), 1'b0);
        cyc(1'b1, mk(4'd3, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0), 1'b1);
        cyc(1'b1, nop(), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        // Reset dropped mid-flush and during a stall
        cyc(1'b1, nop(), 1'b1);
        cyc(1'b0, nop(), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        cyc(1'b1, mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1), 1'b0);
        cyc(1'b0, mk(4'd3, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        cyc(1'b1, nop(), 1'b0);

        // Random traffic: stalled D is re-presented, flushed D becomes a bubble.
        cur = nop();
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 63) != 0);
            br = ($urandom_range(0, 9) == 0);
            if (!last_stall) cur = last_flushd ? nop() : rnd();
            cyc(rv, cur, br);
        end
        cyc(1'b1, nop(), 1'b0);
        cyc(1'b1, nop(), 1'b0);
        @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0, cyc_n);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
